// File: rtl/fetch_32_if.sv
// Instruction-memory bus between fetch_32 (master) and the instruction memory (slave).
// A request is held with a stable address until ack; ack may arrive in the request
// cycle, and data is valid only in the ack cycle. Only one request is outstanding.
interface fetch_32_if;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ack_in;
  logic [31:0] imem_data_in;

  modport master (
    output imem_req_out,
    output imem_addr_out,
    input  imem_ack_in,
    input  imem_data_in
  );

  modport slave (
    input  imem_req_out,
    input  imem_addr_out,
    output imem_ack_in,
    output imem_data_in
  );
endinterface

// File: rtl/fetch_32.sv
// Instruction fetch stage: PC generation, single-outstanding imem handshake, prefetch FIFO.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_32 #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          BUF_DEPTH    = 4
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              stall_in,
  input  logic              redirect_in,
  input  logic [31:0]       redirect_pc_in,
  fetch_32_if.master        imem,
  output logic [31:0]       insn_out,
  output logic [31:0]       insn_pc_out,
  output logic              insn_valid_out,
  output logic              fetch_fault_out,
  output logic [1:0]        dbg_state_out
);

  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_BOOT    = 2'd0,
    S_FETCH   = 2'd1,
    S_DISCARD = 2'd2,
    S_FAULT   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic            outst_q, outst_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic [31:0]     mem_pc_q   [BUF_DEPTH];
  logic [31:0]     mem_pc_d   [BUF_DEPTH];
  logic [31:0]     mem_insn_q [BUF_DEPTH];
  logic [31:0]     mem_insn_d [BUF_DEPTH];
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_insn_q, out_insn_d;
  logic [31:0]     out_pc_q, out_pc_d;

  logic            req;
  logic            ack_ok;
  logic            push;
  logic            pop;
  logic            misalign;
  logic            avail;
  logic [AW-1:0]   head_idx;
  logic [31:0]     redir_pc;

  // The in-flight request keeps req high even if the FIFO fills behind it.
  assign req    = (state_q == S_FETCH) && (outst_q || (count_q < CW'(BUF_DEPTH)));
  assign ack_ok = req && imem.imem_ack_in;
  assign push   = ack_ok && !redirect_in;
  assign pop    = out_valid_q && !stall_in && !redirect_in;

  assign redir_pc = redirect_pc_in & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign        = |redirect_pc_in[1:0];
  assign fetch_fault_out = (state_q == S_FAULT);
`else
  assign misalign        = 1'b0;
  assign fetch_fault_out = 1'b0;
`endif

  assign imem.imem_req_out  = req;
  assign imem.imem_addr_out = req ? pc_q : 32'h0;

  assign insn_out       = out_insn_q;
  assign insn_pc_out    = out_pc_q;
  assign insn_valid_out = out_valid_q;
  assign dbg_state_out  = state_q;

  // Control FSM and PC.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    outst_d = outst_q;
    case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        if (ack_ok) begin
          outst_d = 1'b0;
          pc_d    = pc_q + 32'd4;
        end else if (req) begin
          outst_d = 1'b1;
        end
      end
      S_DISCARD: begin
        if (imem.imem_ack_in) state_d = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_BOOT;
    endcase

    if (redirect_in) begin
      pc_d    = redir_pc;
      outst_d = 1'b0;
      if (misalign) begin
        state_d = S_FAULT;
      end else if ((state_q == S_FETCH) && req && !imem.imem_ack_in) begin
        state_d = S_DISCARD;
      end else if ((state_q == S_DISCARD) && !imem.imem_ack_in) begin
        state_d = S_DISCARD;
      end else begin
        state_d = S_FETCH;
      end
    end
  end

  // Prefetch FIFO and the registered copy of its head.
  always_comb begin
    mem_pc_d   = mem_pc_q;
    mem_insn_d = mem_insn_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    count_d    = count_q + CW'(push) - CW'(pop);

    if (push) begin
      mem_pc_d[wr_q]   = pc_q;
      mem_insn_d[wr_q] = imem.imem_data_in;
      wr_d             = wr_q + AW'(1);
    end
    if (pop) rd_d = rd_q + AW'(1);

    // Head as seen after this cycle's pop; a same-cycle push shows up a cycle later.
    head_idx    = pop ? (rd_q + AW'(1)) : rd_q;
    avail       = pop ? (count_q > CW'(1)) : (count_q != '0);
    out_valid_d = avail;
    out_insn_d  = avail ? mem_insn_q[head_idx] : 32'h0;
    out_pc_d    = avail ? mem_pc_q[head_idx]   : 32'h0;

    if (redirect_in) begin
      rd_d        = '0;
      wr_d        = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
      out_insn_d  = 32'h0;
      out_pc_d    = 32'h0;
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_VECTOR;
      outst_q     <= 1'b0;
      count_q     <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      out_valid_q <= 1'b0;
      out_insn_q  <= 32'h0;
      out_pc_q    <= 32'h0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_pc_q[i]   <= 32'h0;
        mem_insn_q[i] <= 32'h0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      outst_q     <= outst_d;
      count_q     <= count_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      out_valid_q <= out_valid_d;
      out_insn_q  <= out_insn_d;
      out_pc_q    <= out_pc_d;
      mem_pc_q    <= mem_pc_d;
      mem_insn_q  <= mem_insn_d;
    end
  end

endmodule

// File: tb/tb_fetch_32.sv
// Directed bench for fetch_32: table of redirect targets plus hand-written corner sequences.
// The memory model returns addr ^ 32'hA5A5_0000 after mem_wait cycles (0 = same cycle).
module tb_fetch_32;

  localparam logic [31:0] XOR_K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic        insn_valid;
  logic        fault;
  logic [1:0]  dbg_state;

  fetch_32_if bus();

  fetch_32 #(.RESET_VECTOR(32'h0000_0000), .BUF_DEPTH(4)) dut (
    .clk_in          (clk),
    .reset_in        (rst_n),
    .stall_in        (stall),
    .redirect_in     (redirect),
    .redirect_pc_in  (redirect_pc),
    .imem            (bus),
    .insn_out        (insn),
    .insn_pc_out     (insn_pc),
    .insn_valid_out  (insn_valid),
    .fetch_fault_out (fault),
    .dbg_state_out   (dbg_state)
  );

  always #5 clk = ~clk;

  // Instruction memory model; it keeps serving a latched request across DUT reset.
  int          mem_wait = 0;
  logic        busy = 1'b0;
  int          cnt = 0;
  logic [31:0] lat = 32'h0;
  logic        mem_ack;
  int          ack_total = 0;

  always_comb begin
    mem_ack = 1'b0;
    if (busy) mem_ack = (cnt >= mem_wait);
    else      mem_ack = bus.imem_req_out && (mem_wait == 0);
  end

  assign bus.imem_ack_in  = mem_ack;
  assign bus.imem_data_in = (busy ? lat : bus.imem_addr_out) ^ XOR_K;

  always @(posedge clk) begin
    if (mem_ack) begin
      busy      <= 1'b0;
      ack_total <= ack_total + 1;
    end else if (bus.imem_req_out && !busy) begin
      busy <= 1'b1;
      cnt  <= 1;
      lat  <= bus.imem_addr_out;
    end else if (busy) begin
      cnt <= cnt + 1;
    end
  end

  // Scoreboard
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(bus.imem_req_out), 32'd0);
    chk({tag, "_addr"},  bus.imem_addr_out,     32'd0);
    chk({tag, "_insn"},  insn,                  32'd0);
    chk({tag, "_pc"},    insn_pc,               32'd0);
    chk({tag, "_valid"}, 32'(insn_valid),       32'd0);
    chk({tag, "_fault"}, 32'(fault),            32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
  endtask

  // Advance to the next negedge showing a valid head; waits = negedges advanced.
  task automatic next_insn(output logic [31:0] pc, output logic [31:0] ins, output int waits);
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!insn_valid && waits < 40);
    pc  = insn_pc;
    ins = insn;
    if (!insn_valid) chk("valid_timeout", 32'(insn_valid), 32'd1);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    @(negedge clk);
    redirect    = 1'b0;
    chk("redirect_flush_valid", 32'(insn_valid), 32'd0);
  endtask

  typedef struct packed {
    logic [31:0]       target;
    logic [3:0][31:0]  exp_pc;
  } vec_t;

  vec_t vecs[4];

  function automatic vec_t make_vec(input logic [31:0] t, input logic [31:0] p0,
                                    input logic [31:0] p1, input logic [31:0] p2,
                                    input logic [31:0] p3);
    vec_t v;
    v.target    = t;
    v.exp_pc[0] = p0;
    v.exp_pc[1] = p1;
    v.exp_pc[2] = p2;
    v.exp_pc[3] = p3;
    return v;
  endfunction

  initial begin
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] e;
    int          waits;
    int          a0;
    int          k;

    vecs[0] = make_vec(32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108, 32'h0000_010C);
    vecs[1] = make_vec(32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004);
    vecs[2] = make_vec(32'h1234_5670, 32'h1234_5670, 32'h1234_5674, 32'h1234_5678, 32'h1234_567C);
    vecs[3] = make_vec(32'h0000_0FFC, 32'h0000_0FFC, 32'h0000_1000, 32'h0000_1004, 32'h0000_1008);

    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // Reset release with zero-wait memory: 0,4,8,12, first valid on the 3rd cycle
    do_reset();
    for (int j = 0; j < 4; j++) exp_q.push_back(32'(j * 4));
    for (int j = 0; j < 4; j++) begin
      next_insn(pc, ins, waits);
      e = exp_q.pop_front();
      chk("boot_pc", pc, e);
      chk("boot_insn", ins, e ^ XOR_K);
      chk(j == 0 ? "boot_latency" : "boot_no_gap", 32'(waits), (j == 0) ? 32'd3 : 32'd1);
    end

    // Redirect table, including the 32-bit PC wrap
    for (int i = 0; i < 4; i++) begin
      do_redirect(vecs[i].target);
      for (int j = 0; j < 4; j++) exp_q.push_back(vecs[i].exp_pc[j]);
      for (int j = 0; j < 4; j++) begin
        next_insn(pc, ins, waits);
        e = exp_q.pop_front();
        chk("redir_pc", pc, e);
        chk("redir_insn", ins, e ^ XOR_K);
        if (j == 0) chk("redir_latency_ge2", 32'(waits >= 2), 32'd1);
        else        chk("redir_no_gap", 32'(waits), 32'd1);
      end
    end

    // Misaligned redirect
    do_redirect(32'h0000_0202);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("fault_set", 32'(fault), 32'd1);
    chk("fault_state", 32'(dbg_state), 32'd3);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("fault_req", 32'(bus.imem_req_out), 32'd0);
      chk("fault_valid", 32'(insn_valid), 32'd0);
      chk("fault_hold", 32'(fault), 32'd1);
    end
    do_redirect(32'h0000_0200);
    chk("fault_clear", 32'(fault), 32'd0);
    next_insn(pc, ins, waits);
    chk("fault_resume_pc", pc, 32'h0000_0200);
`else
    chk("nofault_flag", 32'(fault), 32'd0);
    next_insn(pc, ins, waits);
    chk("misalign_forced_pc", pc, 32'h0000_0200);
    chk("misalign_forced_insn", ins, 32'h0000_0200 ^ XOR_K);
    do_redirect(32'h0000_0200);
    next_insn(pc, ins, waits);
    chk("aligned_pc", pc, 32'h0000_0200);
`endif

    // Stall for 10 cycles: FIFO fills to 4, then drains in order without gaps
    stall = 1'b1;
    do_reset();
    a0 = ack_total;
    repeat (10) @(negedge clk);
    chk("stall_ack_count", 32'(ack_total - a0), 32'd4);
    chk("stall_req_full", 32'(bus.imem_req_out), 32'd0);
    chk("stall_head_valid", 32'(insn_valid), 32'd1);
    chk("stall_head_pc", insn_pc, 32'd0);
    stall = 1'b0;
    for (int j = 1; j < 5; j++) exp_q.push_back(32'(j * 4));
    for (int j = 1; j < 5; j++) begin
      next_insn(pc, ins, waits);
      e = exp_q.pop_front();
      chk("drain_pc", pc, e);
      chk("drain_no_gap", 32'(waits), 32'd1);
    end

    // Redirect while the request to 0x20 is pending; its ack lands in DISCARD
    do_reset();
    mem_wait = 2;
    k = 0;
    while (!(bus.imem_req_out && bus.imem_addr_out == 32'h20 && !busy) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("discard_setup_found", 32'(k < 200), 32'd1);
    do_redirect(32'h0000_0100);
    chk("discard_state", 32'(dbg_state), 32'd2);
    chk("discard_req", 32'(bus.imem_req_out), 32'd0);
    next_insn(pc, ins, waits);
    chk("discard_first_pc", pc, 32'h0000_0100);
    chk("discard_first_insn", ins, 32'h0000_0100 ^ XOR_K);
    mem_wait = 0;
    next_insn(pc, ins, waits);
    chk("discard_second_pc", pc, 32'h0000_0104);

    // Reset mid-handshake; the late ack must not disturb anything
    do_reset();
    mem_wait = 3;
    k = 0;
    while (!busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("midreset_setup_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    a0 = ack_total;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk_reset_outputs("late_ack");
    end
    chk("late_ack_seen", 32'(ack_total > a0), 32'd1);
    mem_wait = 0;
    rst_n = 1'b1;
    next_insn(pc, ins, waits);
    chk("restart_latency", 32'(waits), 32'd3);
    chk("restart_pc", pc, 32'h0000_0000);
    chk("restart_insn", ins, XOR_K);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
